// File: rtl/icache_assoc.sv
// Set-associative instruction cache with per-set true-LRU replacement and whole-cache flush.
// A miss stalls the fetch stage through BUSYWAIT while one block is fetched and installed.
module icache_assoc #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4,
    parameter int unsigned SETS            = 8,
    parameter int unsigned WAYS            = 2
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic                                      READ,
    input  logic [ADDR_W-1:0]                         ADDRESS,
    input  logic                                      FLUSH,
    output logic [31:0]                               READDATA,
    output logic                                      BUSYWAIT,
    output logic [ADDR_W-$clog2(WORDS_PER_BLOCK)-3:0] MEM_ADDRESS,
    output logic                                      MEM_READ,
    input  logic [32*WORDS_PER_BLOCK-1:0]             MEM_READDATA,
    input  logic                                      MEM_BUSYWAIT
);

    localparam int unsigned OFF_W  = $clog2(WORDS_PER_BLOCK) + 2;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

    typedef logic [WORDS_PER_BLOCK-1:0][31:0] block_t;
    typedef logic [WAYS-1:0][AGE_W-1:0]       age_vec_t;
    typedef enum logic [1:0] {StIdle, StReadMem, StUpdate} state_t;

    state_t            state_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    block_t            data_q  [SETS][WAYS];
    age_vec_t          age_q   [SETS];
    logic              flush_pending_q;
    logic [ADDR_W-1:0] miss_addr_q;
    block_t            fill_buf_q;
    logic              mem_read_q;

    logic [IDX_W-1:0]  idx, miss_idx;
    logic [TAG_W-1:0]  tag, miss_tag;
    logic [WSEL_W-1:0] word_sel;
    logic              hit_any, hit, victim_found;
    int                hit_way, victim;

    function automatic age_vec_t age_reset();
        age_vec_t a;
        for (int i = 0; i < int'(WAYS); i++) a[i] = AGE_W'(i);
        return a;
    endfunction

    // True LRU: touched way becomes youngest, only ways younger than it age by one.
    function automatic age_vec_t lru_touch(input age_vec_t a, input int way);
        age_vec_t r;
        r = a;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (i == way) r[i] = '0;
            else if (a[i] < a[way]) r[i] = a[i] + 1'b1;
        end
        return r;
    endfunction

    assign idx      = ADDRESS[OFF_W +: IDX_W];
    assign tag      = ADDRESS[ADDR_W-1 -: TAG_W];
    assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];

    if (WORDS_PER_BLOCK > 1) begin : g_word_sel
        assign word_sel = ADDRESS[OFF_W-1:2];
    end else begin : g_word_sel_single
        assign word_sel = 1'b0;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ADDRESS[1:0], miss_addr_q[OFF_W-1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_way = 0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = w;
            end
        end
        hit      = (state_q == StIdle) && READ && hit_any && !flush_pending_q && !RESET;
        READDATA = hit ? data_q[idx][hit_way][word_sel] : 32'h0;
        BUSYWAIT = (state_q != StIdle) || flush_pending_q || (READ && !hit_any);
        if (RESET) BUSYWAIT = 1'b0;
    end

    always_comb begin
        victim       = 0;
        victim_found = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!valid_q[miss_idx][w] && !victim_found) begin
                victim       = w;
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (age_q[miss_idx][w] == AGE_W'(WAYS - 1)) victim = w;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= StIdle;
            flush_pending_q <= 1'b0;
            miss_addr_q     <= '0;
            mem_read_q      <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= age_reset();
            end
        end else begin
            // A flush seen outside IDLE waits until the in-flight fill has landed.
            flush_pending_q <= FLUSH || (flush_pending_q && (state_q != StIdle));
            unique case (state_q)
                StIdle: begin
                    if (flush_pending_q) begin
                        for (int s = 0; s < int'(SETS); s++) begin
                            valid_q[s] <= '0;
                            age_q[s]   <= age_reset();
                        end
                    end else if (hit) begin
                        age_q[idx] <= lru_touch(age_q[idx], hit_way);
                    end else if (READ) begin
                        miss_addr_q <= ADDRESS;
                        mem_read_q  <= 1'b1;
                        state_q     <= StReadMem;
                    end
                end
                StReadMem: begin
                    if (!MEM_BUSYWAIT) begin
                        fill_buf_q <= MEM_READDATA;
                        mem_read_q <= 1'b0;
                        state_q    <= StUpdate;
                    end
                end
                StUpdate: begin
                    data_q[miss_idx][victim]  <= fill_buf_q;
                    tag_q[miss_idx][victim]   <= miss_tag;
                    valid_q[miss_idx][victim] <= 1'b1;
                    age_q[miss_idx]           <= lru_touch(age_q[miss_idx], victim);
                    state_q                   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = miss_addr_q[ADDR_W-1:OFF_W];

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: default 2-way instance plus a direct-mapped
// 16-set, 8-word-block instance, each backed by a fixed-latency block memory model.
module tb_icache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         read, flush, busywait, mem_read, mem_busywait;
    logic [31:0]  address, readdata;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;

    logic         s_read, s_flush, s_busywait, s_mem_read, s_mem_busywait;
    logic [31:0]  s_address, s_readdata;
    logic [26:0]  s_mem_address;
    logic [255:0] s_mem_readdata;

    int mem_lat   = 0;
    int mem_cnt   = 0;
    int s_mem_cnt = 0;

    icache_assoc dut (
        .CLK          (clk),
        .RESET        (rst),
        .READ         (read),
        .ADDRESS      (address),
        .FLUSH        (flush),
        .READDATA     (readdata),
        .BUSYWAIT     (busywait),
        .MEM_ADDRESS  (mem_address),
        .MEM_READ     (mem_read),
        .MEM_READDATA (mem_readdata),
        .MEM_BUSYWAIT (mem_busywait)
    );

    icache_assoc #(
        .ADDR_W          (32),
        .WORDS_PER_BLOCK (8),
        .SETS            (16),
        .WAYS            (1)
    ) dut_s (
        .CLK          (clk),
        .RESET        (rst),
        .READ         (s_read),
        .ADDRESS      (s_address),
        .FLUSH        (s_flush),
        .READDATA     (s_readdata),
        .BUSYWAIT     (s_busywait),
        .MEM_ADDRESS  (s_mem_address),
        .MEM_READ     (s_mem_read),
        .MEM_READDATA (s_mem_readdata),
        .MEM_BUSYWAIT (s_mem_busywait)
    );

    // Memory contents: block 0 reads 0x33333333_22222222_11111111_00000000.
    function automatic logic [31:0] mem_word(input logic [31:0] blk, input int w);
        return 32'(w) * 32'h1111_1111 + blk * 32'h0001_0000;
    endfunction

    always_comb begin
        mem_readdata = '0;
        for (int w = 0; w < 4; w++) mem_readdata[w*32 +: 32] = mem_word(32'(mem_address), w);
    end

    always_comb begin
        s_mem_readdata = '0;
        for (int w = 0; w < 8; w++) s_mem_readdata[w*32 +: 32] = mem_word(32'(s_mem_address), w);
    end

    assign mem_busywait   = mem_read && (mem_cnt < mem_lat);
    assign s_mem_busywait = s_mem_read && (s_mem_cnt < mem_lat);

    always @(posedge clk) begin
        mem_cnt   <= mem_read ? mem_cnt + 1 : 0;
        s_mem_cnt <= s_mem_read ? s_mem_cnt + 1 : 0;
    end

    logic [27:0] ep_addr [$];
    int   rd_cycles  = 0;
    int   s_ep_count = 0;
    logic rd_prev    = 1'b0;
    logic s_rd_prev  = 1'b0;

    always @(negedge clk) begin
        if (mem_read === 1'b1 && rd_prev !== 1'b1) ep_addr.push_back(mem_address);
        if (mem_read === 1'b1) rd_cycles = rd_cycles + 1;
        if (s_mem_read === 1'b1 && s_rd_prev !== 1'b1) s_ep_count = s_ep_count + 1;
        rd_prev   = mem_read;
        s_rd_prev = s_mem_read;
    end

    typedef struct {
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input bit sel, input logic [31:0] addr);
        int          off_w;
        logic [31:0] wmask;
        off_w = sel ? 5 : 4;
        wmask = sel ? 32'd7 : 32'd3;
        return mem_word(addr >> off_w, int'((addr >> 2) & wmask));
    endfunction

    // Holds READ until BUSYWAIT drops, then scores data and stall count.
    task automatic fetch(input string tag, input bit sel, input logic [31:0] addr,
                         input int stalls);
        exp_t e;
        int   n;
        logic bw;
        e.data   = exp_word(sel, addr);
        e.stalls = stalls;
        sb_q.push_back(e);
        if (sel) begin
            s_read    = 1'b1;
            s_address = addr;
        end else begin
            read    = 1'b1;
            address = addr;
        end
        n = 0;
        forever begin
            @(negedge clk);
            bw = sel ? s_busywait : busywait;
            if (bw !== 1'b1) break;
            n++;
            if (n > 100) break;
            tick();
        end
        e = sb_q.pop_front();
        check_eq({tag, "_stall"}, 64'(n), 64'(e.stalls));
        check_eq({tag, "_data"}, sel ? s_readdata : readdata, e.data);
        tick();
        if (sel) s_read = 1'b0;
        else read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        read      = 1'b0;
        flush     = 1'b0;
        address   = '0;
        s_read    = 1'b0;
        s_flush   = 1'b0;
        s_address = '0;
        tick();
        tick();

        // Outputs stay quiet while reset is held, even with a request present.
        read = 1'b1;
        @(negedge clk);
        check_eq("rst_busywait", busywait, 0);
        check_eq("rst_readdata", readdata, 0);
        read = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_mem_read", mem_read, 0);
        check_eq("idle_mem_addr", mem_address, 0);
        check_eq("idle_busywait", busywait, 0);
        check_eq("idle_readdata", readdata, 0);
        tick();

        mem_lat = 4;
        fetch("cold_000", 1'b0, 32'h0, 7);
        check_eq("cold_rd_cycles", rd_cycles, 5);
        check_eq("cold_episodes", ep_addr.size(), 1);
        check_eq("cold_mem_addr", ep_addr[0], 28'h0);
        fetch("hit_008", 1'b0, 32'h8, 0);

        mem_lat = 0;
        fetch("fill_080", 1'b0, 32'h80, 3);
        fetch("touch_000", 1'b0, 32'h0, 0);
        fetch("evict_100", 1'b0, 32'h100, 3);
        fetch("keep_000", 1'b0, 32'h0, 0);
        n = ep_addr.size();
        fetch("refill_080", 1'b0, 32'h80, 3);
        check_eq("refill_mem_addr", ep_addr[n], 28'h8);
        fetch("keep2_000", 1'b0, 32'h0, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_stall", busywait, 1);
        tick();
        @(negedge clk);
        check_eq("flush_done", busywait, 0);
        tick();
        n = ep_addr.size();
        fetch("post_flush_000", 1'b0, 32'h0, 3);
        check_eq("post_flush_episode", ep_addr.size() - n, 1);

        mem_lat = 3;
        n = ep_addr.size();
        fork
            fetch("flush_fill_040", 1'b0, 32'h40, 13);
            begin
                tick();
                tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
        join
        check_eq("flush_fill_episodes", ep_addr.size() - n, 2);
        check_eq("flush_fill_addr0", ep_addr[n], 28'h4);
        check_eq("flush_fill_addr1", ep_addr[n+1], 28'h4);

        mem_lat = 4;
        read    = 1'b1;
        address = 32'hC0;
        tick();
        tick();
        rst  = 1'b1;
        read = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_mem_read", mem_read, 0);
        check_eq("midrst_busywait", busywait, 0);
        check_eq("midrst_mem_addr", mem_address, 0);
        tick();
        mem_lat = 0;
        fetch("post_rst_000", 1'b0, 32'h0, 3);
        fetch("post_rst_0c0", 1'b0, 32'hC0, 3);
        fetch("post_rst_040", 1'b0, 32'h40, 3);

        mem_lat = 1;
        n = s_ep_count;
        fetch("dm_01c", 1'b1, 32'h1C, 4);
        fetch("dm_200", 1'b1, 32'h200, 4);
        fetch("dm_000", 1'b1, 32'h0, 4);
        fetch("dm_200b", 1'b1, 32'h200, 4);
        fetch("dm_204", 1'b1, 32'h204, 0);
        fetch("dm_000b", 1'b1, 32'h0, 4);
        check_eq("dm_episodes", s_ep_count - n, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
